// File: rtl/write_pointer_handler.sv
// Transmit-domain write pointer for the async FIFO: write counter, registered Gray
// pointer for CDC, and full/almost-full/fill/overflow status from the synced read pointer.
module write_pointer_handler #(
    parameter int ADDR_W    = 3,   // must be >= 2
    parameter int AF_MARGIN = 2
) (
    input  logic              clk_tx,
    input  logic              rst_tx,
    input  logic              push,
    input  logic              overflow_clr,
    input  logic [ADDR_W:0]   synced_graycoded_read_pointer,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_pointer,
    output logic [ADDR_W:0]   graycoded_write_pointer,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   fill_level,
    output logic              overflow
);

    localparam int DEPTH = 1 << ADDR_W;
    // Full when the Gray pointers differ only in their two top bits.
    localparam logic [ADDR_W:0] FULL_MASK = {2'b11, {(ADDR_W-1){1'b0}}};
    localparam logic [ADDR_W:0] AF_THRESH = (ADDR_W+1)'(DEPTH - AF_MARGIN);

    logic [ADDR_W:0] wcnt_q, wcnt_d;
    logic [ADDR_W:0] gwp_q, gwp_d;
    logic            ovf_q, ovf_d;
    logic [ADDR_W:0] wgray;
    logic [ADDR_W:0] rb;

    assign wgray = wcnt_q ^ (wcnt_q >> 1);

    always_comb begin
        rb         = '0;
        rb[ADDR_W] = synced_graycoded_read_pointer[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            rb[i] = rb[i+1] ^ synced_graycoded_read_pointer[i];
        end
    end

    assign full        = (wgray == (synced_graycoded_read_pointer ^ FULL_MASK));
    assign fill_level  = wcnt_q - rb;
    assign almost_full = (fill_level >= AF_THRESH);
    // Suppressed during reset so nothing lands in memory on the reset edge.
    assign write_en    = push & ~full & ~rst_tx;

    always_comb begin
        wcnt_d = wcnt_q;
        gwp_d  = wgray;
        ovf_d  = ovf_q;
        if (push && !full) begin
            wcnt_d = wcnt_q + 1'b1;
        end
        if (push && full) begin
            ovf_d = 1'b1;
        end else if (overflow_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_tx) begin
        if (rst_tx) begin
            wcnt_q <= '0;
            gwp_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            gwp_q  <= gwp_d;
            ovf_q  <= ovf_d;
        end
    end

    assign write_pointer           = wcnt_q[ADDR_W-1:0];
    assign graycoded_write_pointer = gwp_q;
    assign overflow                = ovf_q;

endmodule

// File: tb/tb_write_pointer_handler.sv
// Directed bench for write_pointer_handler (ADDR_W=3, AF_MARGIN=2).
module tb_write_pointer_handler;

    logic       clk_tx = 1'b0;
    logic       rst_tx = 1'b0;
    logic       push = 1'b0;
    logic       overflow_clr = 1'b0;
    logic [3:0] rp = 4'b0000;
    logic       write_en;
    logic [2:0] write_pointer;
    logic [3:0] gwp;
    logic       full;
    logic       almost_full;
    logic [3:0] fill_level;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    write_pointer_handler #(.ADDR_W(3), .AF_MARGIN(2)) dut (
        .clk_tx                        (clk_tx),
        .rst_tx                        (rst_tx),
        .push                          (push),
        .overflow_clr                  (overflow_clr),
        .synced_graycoded_read_pointer (rp),
        .write_en                      (write_en),
        .write_pointer                 (write_pointer),
        .graycoded_write_pointer       (gwp),
        .full                          (full),
        .almost_full                   (almost_full),
        .fill_level                    (fill_level),
        .overflow                      (overflow)
    );

    always #5 clk_tx = ~clk_tx;

    task automatic tick();
        @(posedge clk_tx);
        #1;
    endtask

    task automatic test_reset();
        rst_tx = 1'b1; push = 1'b0; overflow_clr = 1'b0; rp = 4'b0000;
        tick(); tick();
        rst_tx = 1'b0;
        #1;
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_af got %b exp 0", almost_full); end
        checks++; if (fill_level !== 4'd0) begin errors++; $display("FAIL rst_fill got %0d exp 0", fill_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", overflow); end
        checks++; if (gwp !== 4'b0000) begin errors++; $display("FAIL rst_gwp got %b exp 0000", gwp); end
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL rst_wen got %b exp 0", write_en); end
        checks++; if (write_pointer !== 3'd0) begin errors++; $display("FAIL rst_wp got %0d exp 0", write_pointer); end
    endtask

    task automatic test_fill();
        rp = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            push = 1'b1;
            #1;
            checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL fill_wen k=%0d got %b exp 1", k, write_en); end
            checks++; if (write_pointer !== 3'(k-1)) begin errors++; $display("FAIL fill_wp k=%0d got %0d exp %0d", k, write_pointer, k-1); end
            tick();
            push = 1'b0;
            #1;
            checks++; if (fill_level !== 4'(k)) begin errors++; $display("FAIL fill_lvl k=%0d got %0d exp %0d", k, fill_level, k); end
            checks++; if (almost_full !== (k >= 6)) begin errors++; $display("FAIL fill_af k=%0d got %b exp %b", k, almost_full, (k >= 6)); end
            checks++; if (full !== (k == 8)) begin errors++; $display("FAIL fill_full k=%0d got %b exp %b", k, full, (k == 8)); end
        end
        // Gray register still holds gray(7) right after full asserts
        checks++; if (gwp !== 4'b0100) begin errors++; $display("FAIL gwp_lag got %b exp 0100", gwp); end
        tick();
        checks++; if (gwp !== 4'b1100) begin errors++; $display("FAIL gwp_full got %b exp 1100", gwp); end
    endtask

    task automatic test_overflow();
        push = 1'b1;
        #1;
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL ovf_wen got %b exp 0", write_en); end
        tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        checks++; if (fill_level !== 4'd8) begin errors++; $display("FAIL ovf_hold got %0d exp 8", fill_level); end
        checks++; if (write_pointer !== 3'd0) begin errors++; $display("FAIL ovf_wp got %0d exp 0", write_pointer); end
        overflow_clr = 1'b1;
        tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_setclr got %b exp 1", overflow); end
        push = 1'b0;
        tick();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", overflow); end
        overflow_clr = 1'b0;
    endtask

    task automatic test_rp_move();
        push = 1'b0;
        rp = 4'b0001;
        #1;
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rp_full got %b exp 0", full); end
        checks++; if (fill_level !== 4'd7) begin errors++; $display("FAIL rp_fill got %0d exp 7", fill_level); end
        push = 1'b1;
        #1;
        checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL rp_wen got %b exp 1", write_en); end
        tick();
        push = 1'b0;
        #1;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL rp_refull got %b exp 1", full); end
        checks++; if (write_pointer !== 3'd1) begin errors++; $display("FAIL rp_wp got %0d exp 1", write_pointer); end
    endtask

    task automatic test_wrap();
        // counter is 9; read side catches up to 9 (gray 1101)
        rp = 4'b1101;
        for (int k = 0; k < 6; k++) begin
            push = 1'b1;
            tick();
        end
        push = 1'b0;
        rp = 4'b1001;   // read count 14
        tick();
        checks++; if (write_pointer !== 3'd7) begin errors++; $display("FAIL wrap_wp7 got %0d exp 7", write_pointer); end
        checks++; if (gwp !== 4'b1000) begin errors++; $display("FAIL wrap_gwp15 got %b exp 1000", gwp); end
        checks++; if (fill_level !== 4'd1) begin errors++; $display("FAIL wrap_fill1 got %0d exp 1", fill_level); end
        push = 1'b1;
        #1;
        checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL wrap_wen got %b exp 1", write_en); end
        tick();
        push = 1'b0;
        #1;
        checks++; if (write_pointer !== 3'd0) begin errors++; $display("FAIL wrap_wp0 got %0d exp 0", write_pointer); end
        checks++; if (fill_level !== 4'd2) begin errors++; $display("FAIL wrap_fill2 got %0d exp 2", fill_level); end
        checks++; if (gwp !== 4'b1000) begin errors++; $display("FAIL wrap_gwp_lag got %b exp 1000", gwp); end
        tick();
        checks++; if (gwp !== 4'b0000) begin errors++; $display("FAIL wrap_gwp0 got %b exp 0000", gwp); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL wrap_af got %b exp 0", almost_full); end
    endtask

    task automatic test_reset_mid();
        // counter 0: fill to full, then overflow
        rp = 4'b0000;
        for (int k = 0; k < 9; k++) begin
            push = 1'b1;
            tick();
        end
        push = 1'b0;
        #1;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL mid_ovf_pre got %b exp 1", overflow); end
        rp = 4'b0110;   // read count 4
        push = 1'b1;
        tick();         // counter 9
        checks++; if (fill_level !== 4'd5) begin errors++; $display("FAIL mid_fill_pre got %0d exp 5", fill_level); end
        rst_tx = 1'b1;
        #1;
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL mid_wen got %b exp 0", write_en); end
        tick();
        rst_tx = 1'b0;
        push = 1'b0;
        rp = 4'b0000;
        #1;
        checks++; if (write_pointer !== 3'd0) begin errors++; $display("FAIL mid_wp got %0d exp 0", write_pointer); end
        checks++; if (fill_level !== 4'd0) begin errors++; $display("FAIL mid_fill got %0d exp 0", fill_level); end
        checks++; if (gwp !== 4'b0000) begin errors++; $display("FAIL mid_gwp got %b exp 0000", gwp); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b exp 0", overflow); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_rp_move();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
